// File: rtl/bomb_pkg.sv
// Shared game definitions for the bomb controller, display and puzzle blocks.
package bomb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ARMED    = 2'b01,
    ST_EXPLODED = 2'b10,
    ST_DEFUSED  = 2'b11
  } game_state_t;

  localparam int DEFAULT_CLOCK_HZ = 27_000_000;
  localparam int STRIKE_W         = 3;
  localparam int SECONDS_W        = 10;

endpackage

// File: rtl/tick_gen.sv
// One-second tick divider: counts 0..CLOCK_HZ-1 while run is high, tick is high on the wrap cycle.
// Counter returns to zero whenever run is low, so every arming starts a full second.
module tick_gen
  import bomb_pkg::*;
#(
  parameter int CLOCK_HZ = DEFAULT_CLOCK_HZ
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int              CNT_W = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLOCK_HZ - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!run || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/bomb_status.sv
// Bomb game controller: arming, strike counting, countdown and explode/defuse resolution.
// All outputs registered; a state change is visible one cycle after the causing input.
module bomb_status
  import bomb_pkg::*;
#(
  parameter int NUM_MODULES   = 4,
  parameter int MAX_STRIKES   = 3,
  parameter int CLOCK_HZ      = DEFAULT_CLOCK_HZ,
  parameter int START_SECONDS = 300
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_MODULES-1:0] strike,
  input  logic [NUM_MODULES-1:0] module_defused,
  output logic [NUM_MODULES-1:0] module_enable,
  output logic [STRIKE_W-1:0]    strike_count,
  output logic [SECONDS_W-1:0]   seconds_left,
  output logic [1:0]             game_state,
  output logic                   exploded,
  output logic                   bomb_defused
);

  localparam int                   SUM_W     = STRIKE_W + $clog2(NUM_MODULES + 1);
  localparam logic [SUM_W-1:0]     SUM_MAX   = SUM_W'(MAX_STRIKES);
  localparam logic [SECONDS_W-1:0] SEC_START = SECONDS_W'(START_SECONDS);

  game_state_t            r_state, w_state_next;
  logic [NUM_MODULES-1:0] r_strike_q, w_strike_rise;
  logic [STRIKE_W-1:0]    r_strike_count, w_strike_next;
  logic [SECONDS_W-1:0]   r_seconds, w_seconds_next;
  logic [NUM_MODULES-1:0] r_enable, w_enable;
  logic                   r_exploded, w_exploded;
  logic                   r_defused, w_defused;
  logic [SUM_W-1:0]       w_sum;
  logic                   w_tick, w_run, w_arming;
  logic                   w_boom_strike, w_boom_time, w_all_defused;

  tick_gen #(
    .CLOCK_HZ(CLOCK_HZ)
  ) u_tick_gen (
    .clock(clock),
    .reset(reset),
    .run  (w_run),
    .tick (w_tick)
  );

  assign w_run         = (r_state == ST_ARMED);
  assign w_arming      = (r_state == ST_IDLE) && start;
  assign w_strike_rise = strike & ~r_strike_q;
  assign w_all_defused = &module_defused;

  // Several modules may strike in the same cycle; each rising bit adds one.
  always_comb begin
    w_sum = SUM_W'(r_strike_count);
    for (int i = 0; i < NUM_MODULES; i++) begin
      w_sum = w_sum + SUM_W'(w_strike_rise[i]);
    end
  end

  assign w_boom_strike  = w_run && (w_sum >= SUM_MAX);
  assign w_strike_next  = (w_sum >= SUM_MAX) ? STRIKE_W'(MAX_STRIKES) : w_sum[STRIKE_W-1:0];
  assign w_seconds_next = (w_tick && (r_seconds != '0)) ? r_seconds - SECONDS_W'(1) : r_seconds;
  assign w_boom_time    = w_run && w_tick && (r_seconds == SECONDS_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_enable   <= '0;
      r_exploded <= 1'b0;
      r_defused  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_enable   <= w_enable;
      r_exploded <= w_exploded;
      r_defused  <= w_defused;
    end
  end

  // Explosion is checked first so it beats a simultaneous defuse.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_boom_strike || w_boom_time) w_state_next = ST_EXPLODED;
        else if (w_all_defused)           w_state_next = ST_DEFUSED;
      end
      default: w_state_next = r_state;
    endcase
  end

  always_comb begin
    w_enable   = {NUM_MODULES{w_state_next == ST_ARMED}};
    w_exploded = (w_state_next == ST_EXPLODED);
    w_defused  = (w_state_next == ST_DEFUSED);
  end

  // Counters only move while armed, so they freeze once the game ends.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_strike_q     <= '0;
      r_strike_count <= '0;
      r_seconds      <= SEC_START;
    end else begin
      r_strike_q <= strike;
      if (w_arming) begin
        r_strike_count <= '0;
        r_seconds      <= SEC_START;
      end else if (w_run) begin
        r_strike_count <= w_strike_next;
        r_seconds      <= w_seconds_next;
      end
    end
  end

  assign module_enable = r_enable;
  assign strike_count  = r_strike_count;
  assign seconds_left  = r_seconds;
  assign game_state    = r_state;
  assign exploded      = r_exploded;
  assign bomb_defused  = r_defused;

endmodule

// File: tb/tb_bomb_status.sv
// Scoreboard bench for bomb_status: stimulus queues expected outputs tagged with a due cycle,
// a monitor pops and compares them at the falling edge (or on an asynchronous probe).
module tb_bomb_status;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_ARM  = 2'b01;
    localparam logic [1:0] S_EXP  = 2'b10;
    localparam logic [1:0] S_DEF  = 2'b11;

    typedef struct packed {
        logic [1:0] st;
        logic [9:0] sec;
        logic [2:0] sc;
        logic [3:0] en;
        logic       ex;
        logic       df;
    } obs_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] strike;
    logic [3:0] module_defused;
    logic [3:0] module_enable;
    logic [2:0] strike_count;
    logic [9:0] seconds_left;
    logic [1:0] game_state;
    logic       exploded;
    logic       bomb_defused;
    logic       probe;

    int    cyc = 0;
    int    n_vec = 0;
    int    n_err = 0;
    int    due_q[$];
    obs_t  exp_q[$];
    string nm_q[$];

    bomb_status #(
        .NUM_MODULES  (4),
        .MAX_STRIKES  (3),
        .CLOCK_HZ     (10),
        .START_SECONDS(5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .strike        (strike),
        .module_defused(module_defused),
        .module_enable (module_enable),
        .strike_count  (strike_count),
        .seconds_left  (seconds_left),
        .game_state    (game_state),
        .exploded      (exploded),
        .bomb_defused  (bomb_defused)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_at(input int k, input string nm, input logic [1:0] st,
                             input int sec, input int sc, input logic [3:0] en);
        obs_t o;
        o.st  = st;
        o.sec = 10'(sec);
        o.sc  = 3'(sc);
        o.en  = en;
        o.ex  = (st == S_EXP);
        o.df  = (st == S_DEF);
        due_q.push_back(cyc + k);
        exp_q.push_back(o);
        nm_q.push_back(nm);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (due_q.size() == 0) break;
            @(negedge clock);
            #1;
        end
        step(1);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        strike         = 4'b0000;
        module_defused = 4'b0000;
        step(2);
        expect_at(0, "reset_state", S_IDLE, 5, 0, 4'b0000);
        reset = 1'b0;
        step(1);
    endtask

    // Monitor: compare every expectation whose due cycle has arrived.
    initial begin
        obs_t  e;
        obs_t  a;
        string nm;
        forever begin
            @(negedge clock or posedge probe);
            while (due_q.size() > 0 && due_q[0] <= cyc) begin
                void'(due_q.pop_front());
                e  = exp_q.pop_front();
                nm = nm_q.pop_front();
                a  = {game_state, seconds_left, strike_count, module_enable, exploded, bomb_defused};
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d: got st=%0d sec=%0d strikes=%0d en=%b ex=%b df=%b, want st=%0d sec=%0d strikes=%0d en=%b ex=%b df=%b",
                             nm, cyc, a.st, a.sec, a.sc, a.en, a.ex, a.df, e.st, e.sec, e.sc, e.en, e.ex, e.df);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; strike = 4'b0000; module_defused = 4'b0000; probe = 1'b0;
        step(2);
        expect_at(0, "power_on_reset", S_IDLE, 5, 0, 4'b0000);
        reset = 1'b0;
        step(3);
        expect_at(0, "idle_hold", S_IDLE, 5, 0, 4'b0000);
        step(1);

        // Countdown to zero with no activity.
        pulse_start();
        expect_at(0,  "cd_armed",    S_ARM, 5, 0, 4'b1111);
        expect_at(9,  "cd_pre_tick", S_ARM, 5, 0, 4'b1111);
        expect_at(10, "cd_4",        S_ARM, 4, 0, 4'b1111);
        expect_at(20, "cd_3",        S_ARM, 3, 0, 4'b1111);
        expect_at(30, "cd_2",        S_ARM, 2, 0, 4'b1111);
        expect_at(40, "cd_1",        S_ARM, 1, 0, 4'b1111);
        expect_at(49, "cd_last_1",   S_ARM, 1, 0, 4'b1111);
        expect_at(50, "cd_boom",     S_EXP, 0, 0, 4'b0000);
        step(52);
        if (game_state !== S_EXP || seconds_left !== 10'd0 || exploded !== 1'b1) begin
            n_err++;
            $display("FAIL cd_direct: st=%0d sec=%0d ex=%b", game_state, seconds_left, exploded);
        end
        n_vec++;
        pulse_start();
        expect_at(2, "start_in_exploded", S_EXP, 0, 0, 4'b0000);
        drain();

        // Held strike counts once, a later pulse counts, then two together detonate.
        do_reset();
        pulse_start();
        strike = 4'b0001;
        expect_at(1, "strike_first", S_ARM, 5, 1, 4'b1111);
        step(30);
        strike = 4'b0000;
        expect_at(0, "strike_held_once", S_ARM, 2, 1, 4'b1111);
        step(2);
        strike = 4'b0100;
        step(1);
        strike = 4'b0000;
        expect_at(0, "strike_second", S_ARM, 2, 2, 4'b1111);
        step(2);
        strike = 4'b1010;
        step(1);
        expect_at(0, "strike_boom",   S_EXP, 2, 3, 4'b0000);
        expect_at(9, "strike_frozen", S_EXP, 2, 3, 4'b0000);
        drain();

        // Progressive defuse.
        do_reset();
        pulse_start();
        step(3); module_defused = 4'b0001;
        step(3); module_defused = 4'b0011;
        step(3); module_defused = 4'b0111;
        expect_at(0, "def_three", S_ARM, 5, 0, 4'b1111);
        step(3); module_defused = 4'b1111;
        expect_at(0,  "def_pre",    S_ARM, 4, 0, 4'b1111);
        expect_at(1,  "defused",    S_DEF, 4, 0, 4'b0000);
        expect_at(13, "def_frozen", S_DEF, 4, 0, 4'b0000);
        drain();

        // Third strike and full defuse arrive together; explosion wins.
        do_reset();
        pulse_start();
        strike = 4'b0011;
        expect_at(1, "multi_edge", S_ARM, 5, 2, 4'b1111);
        step(1);
        strike = 4'b0000;
        step(1);
        strike = 4'b0100;
        module_defused = 4'b1111;
        expect_at(1, "collision", S_EXP, 5, 3, 4'b0000);
        step(1);
        strike = 4'b0000;
        module_defused = 4'b0000;
        drain();

        // Asynchronous reset mid-countdown, between clock edges.
        do_reset();
        pulse_start();
        strike = 4'b0001;
        step(30);
        expect_at(0, "pre_reset", S_ARM, 2, 1, 4'b1111);
        @(negedge clock);
        #1;
        reset = 1'b1;
        expect_at(0, "async_reset", S_IDLE, 5, 0, 4'b0000);
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        if (game_state !== S_IDLE || seconds_left !== 10'd5 || strike_count !== 3'd0
            || module_enable !== 4'b0000) begin
            n_err++;
            $display("FAIL async_direct: st=%0d sec=%0d strikes=%0d en=%b",
                     game_state, seconds_left, strike_count, module_enable);
        end
        n_vec++;
        strike = 4'b0000;
        step(2);
        expect_at(0, "reset_held", S_IDLE, 5, 0, 4'b0000);
        reset = 1'b0;
        step(3);
        expect_at(0, "idle_after_reset", S_IDLE, 5, 0, 4'b0000);
        drain();

        // Strike level already high before arming must not count.
        do_reset();
        strike = 4'b1000;
        step(3);
        pulse_start();
        expect_at(0,  "prearm_start", S_ARM, 5, 0, 4'b1111);
        expect_at(12, "prearm_held",  S_ARM, 4, 0, 4'b1111);
        step(12);
        strike = 4'b0000;
        step(1);
        strike = 4'b1000;
        step(1);
        expect_at(0, "prearm_rerise", S_ARM, 4, 1, 4'b1111);
        drain();

        while (due_q.size() > 0) begin
            n_err++;
            $display("FAIL %s: expectation due at cyc %0d never compared (now %0d)", nm_q[0], due_q[0], cyc);
            void'(due_q.pop_front());
            void'(exp_q.pop_front());
            void'(nm_q.pop_front());
        end

        if (n_vec < 12) begin
            n_err++;
            $display("FAIL coverage: only %0d vectors compared", n_vec);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
